// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with fixed access latency and stall/ready handshake.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_ready,
    output logic        stall,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           we_q, we_d;
    logic           mis_q, mis_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q;
    logic           req;
    logic           unused_addr;

    logic [31:0]    ram [DEPTH];

    assign req         = mem_read | mem_write;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        mis_d   = mis_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    // A simultaneous read+write is serviced as a write.
                    we_d    = mem_write;
                    idx_d   = addr[AW+1:2];
                    wdata_d = wdata;
                    cnt_d   = 4'(LATENCY - 1);
`ifdef DMEM_MISALIGN_TRAP_EN
                    mis_d   = (addr[1:0] != 2'b00);
`else
                    mis_d   = 1'b0;
`endif
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            // Load result is captured on entry to DONE so it is visible with mem_ready.
            if (state_q == BUSY && cnt_q == 4'd0 && !we_q && !mis_q) begin
                rdata_q <= ram[idx_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == DONE && we_q && !mis_q) begin
            ram[idx_q] <= wdata_q;
        end
    end

    assign rdata     = rdata_q;
    assign mem_ready = (state_q == DONE);
    assign stall     = req & ~mem_ready;
    assign busy      = (state_q != IDLE);
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misaligned = (state_q == DONE) & mis_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table with an expected-result queue,
// plus hand-written reset-during-access and request-drop sequences.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        stall;
    logic        busy;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    dmem_responder #(.DEPTH(256), .AW(8), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .mem_ready (mem_ready),
        .stall     (stall),
`ifdef DMEM_MISALIGN_TRAP_EN
        .misaligned(misaligned),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts just after a rising edge with the DUT idle; returns just after the edge ending DONE.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] er, input logic em);
        exp_t        e;
        int          cyc = 0;
        int          st  = 0;
        logic        got = 1'b0;
        logic [31:0] rd_seen = '0;
        logic        mis_seen = 1'b0;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        sb.push_back('{rdata: er, mis: em});
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (stall) st++;
            if (mem_ready) begin
                got     = 1'b1;
                rd_seen = rdata;
`ifdef DMEM_MISALIGN_TRAP_EN
                mis_seen = misaligned;
`endif
            end else begin
                cyc++;
            end
        end
        check("ready_seen", 32'(got), 32'd1);
        e = sb.pop_front();
        if (got) begin
            check("latency", 32'(cyc), 32'(LAT + 1));
            check("stall_cycles", 32'(st), 32'(LAT + 1));
            check("rdata", rd_seen, e.rdata);
`ifdef DMEM_MISALIGN_TRAP_EN
            check("misaligned", 32'(mis_seen), 32'(e.mis));
`else
            check("mis_unused", 32'(mis_seen), 32'(e.mis & 1'b0));
`endif
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int cnt;
        logic seen;

        vecs[0]  = '{1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h010, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h404, 32'h12345678, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h004, 32'h00000000, 32'h12345678, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h020, 32'hA5A5A5A5, 32'h12345678, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h020, 32'h00000000, 32'hA5A5A5A5, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h030, 32'h22222222, 32'hA5A5A5A5, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'hA5A5A5A5, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h7FC, 32'h00000000, 32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h040, 32'h0BADF00D, 32'hCAFEF00D, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs[10] = '{1'b0, 1'b1, 32'h042, 32'h55AA55AA, 32'hCAFEF00D, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 32'h040, 32'h00000000, 32'h0BADF00D, 1'b0};
`else
        vecs[10] = '{1'b0, 1'b1, 32'h042, 32'h55AA55AA, 32'hCAFEF00D, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h040, 32'h00000000, 32'h55AA55AA, 1'b0};
`endif

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_ready", 32'(mem_ready), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd,
                   vecs[i].exp_rdata, vecs[i].exp_mis);
        end

        // Reset during the BUSY phase of a store: write must be discarded.
        mem_write = 1'b1; addr = 32'h030; wdata = 32'h11111111;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", 32'(mem_ready), 32'd0);
        check("midrst_busy_clr", 32'(busy), 32'd0);
        check("midrst_stall_eq_req", 32'(stall), 32'd1);
        check("midrst_rdata", rdata, 32'h0);
        rst = 1'b0; mem_write = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_ready) pulses++;
        end
        check("midrst_no_pulse", 32'(pulses), 32'd0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'h030, 32'h0, 32'h22222222, 1'b0);

        // Request dropped after acceptance: access still completes and commits.
        mem_write = 1'b1; addr = 32'h050; wdata = 32'h77777777;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        cnt = 0; seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            cnt++;
            if (mem_ready) begin
                seen = 1'b1;
                check("drop_stall_low", 32'(stall), 32'd0);
            end
        end
        check("drop_ready_cycle", 32'(cnt), 32'(LAT + 1));
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'h050, 32'h0, 32'h77777777, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Word-addressed data-memory responder. Services the load/store requests that the decoder raises as mem_read / mem_write.
- Sits between the execute/memory stage and the on-chip data RAM.
- Adds a fixed, parameterised access latency with a stall/ready handshake, so the pipeline holds while an access is in flight.
- Write data commits only when the access completes.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two.
- AW, 8, word-index width; must equal log2(DEPTH).
- LATENCY, 2, cycles from request acceptance to completion; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load request (LW).
- mem_write  in  1  store request (SW).
- addr  in  32  byte address.
- wdata  in  32  store data.
- rdata  out  32  load data; valid when mem_ready=1 for a read.
- mem_ready  out  1  one-cycle completion pulse.
- stall  out  1  pipeline hold request.
- busy  out  1  FSM not in IDLE.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: rdata=0, mem_ready=0, busy=0, FSM=IDLE, latency counter=0. RAM contents are not reset.
- req = mem_read | mem_write. If both are high, the request is treated as a write and the read is ignored.
- stall = req & ~mem_ready. It is combinational, so it is high in the same cycle a request first appears.
- FSM:
  - IDLE: on req, latch op, addr[AW+1:2], wdata; cnt <- LATENCY-1; go to BUSY. Without req, stay in IDLE.
  - BUSY: if cnt==0 go to DONE, else cnt <- cnt-1. The request inputs are ignored (the latched copy is used).
  - DONE: mem_ready=1 for exactly this cycle.
    - Write: RAM[idx] <- wdata_latched, committed at the DONE clock edge.
    - Read: rdata <- RAM[idx] and is visible in DONE.
    - Next state is IDLE unconditionally.
- Latency: a request seen in IDLE at cycle T gives mem_ready at cycle T+LATENCY+1. With the default, that is 3 cycles.
- The pipeline must keep the request asserted until it sees mem_ready. It advances on the cycle mem_ready is high.
- A request still asserted in the IDLE cycle after DONE is a new access; there is no back-to-back pipelining.
- rdata holds the last read result until the next read completes. Writes do not change rdata.
- Addressing:
  - index = addr[AW+1:2].
  - Upper bits are ignored, so addresses wrap modulo DEPTH*4. For example, addr 0x400 aliases 0x000 at DEPTH=256.
  - addr[1:0] handling is defined under Optional Feature.
- Reset mid-operation: FSM returns to IDLE and the pending write is discarded (RAM is unchanged). mem_ready=0 and stall=req on the first cycle after reset.
- If req drops while in BUSY, the access still completes; mem_ready pulses and the write still commits.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned (1 bit, reset 0).
  - A request in IDLE with addr[1:0]!=0 moves to DONE after the normal latency with misaligned=1 and mem_ready=1 for that cycle.
  - No RAM write occurs and rdata is unchanged.
  - misaligned is 0 in all other cycles.
- Undefined: the misaligned port is absent, addr[1:0] is ignored, and the access proceeds normally on the truncated word index.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no req -> rdata=0, mem_ready=0, stall=0, busy=0.
- Store then load: SW addr=0x10 wdata=0xDEADBEEF, held until ready -> mem_ready at T+3. Then LW addr=0x10 -> rdata=0xDEADBEEF with mem_ready at T+3. stall is high on exactly 3 cycles of each access.
- Wrap-around: SW addr=0x404 data=0x12345678; LW addr=0x004 -> rdata=0x12345678.
- Simultaneous read+write: mem_read=mem_write=1, addr=0x20, wdata=0xA5A5A5A5 -> treated as a write, rdata unchanged; a subsequent LW 0x20 returns 0xA5A5A5A5.
- Reset mid-write: SW addr=0x30 data=0x11111111 after earlier SW 0x30=0x22222222; assert rst in the BUSY cycle -> no mem_ready pulse; LW 0x30 returns 0x22222222.
- With DMEM_MISALIGN_TRAP_EN: SW addr=0x42 -> misaligned=1 and mem_ready=1 at T+3; LW 0x40 returns the prior contents. Without the macro: same SW writes word 0x40.
